interval_timer_arbiter: RTL and testbench
=========================================

Name: interval_timer_arbiter

Overview:
- Shares one CNT_W-bit interval counter between two requesters.
- Each requester asks for a timed interval of len ticks. The arbiter grants the counter round-robin, runs the count and pulses a per-requester done.
- Sits above the ripple-enable T flip-flop counter datapath and sequences it. The square-wave and timing blocks use it to obtain exclusive timed windows.

Parameters:
- CNT_W, 6, width of interval counter and of len0/len1.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
- req0  in  1  requester 0 wants the timer; must stay high until done0.
- len0  in  CNT_W  requester 0 interval length in ticks; 0 encodes 2^CNT_W.
- req1  in  1  requester 1 request, same rules as req0.
- len1  in  CNT_W  requester 1 interval length.
- gnt0  out  1  requester 0 owns the timer.
- gnt1  out  1  requester 1 owns the timer.
- done0  out  1  one-cycle pulse: requester 0 interval complete.
- done1  out  1  one-cycle pulse: requester 1 interval complete.
- busy  out  1  high in RUN and DONE states.
- count  out  CNT_W  current interval count, 0 outside RUN.

Behaviour:
- Reset (reset==0 at edge):
  - State goes to IDLE.
  - count=0; gnt0=gnt1=done0=done1=busy=0.
  - Round-robin pointer set to favour requester 0.
  - Latched length and owner are cleared.
  - Reset mid-RUN or mid-DONE aborts with no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one req high: select it.
  - Both high: select the requester the pointer favours.
  - On selection: latch owner, latch term = len_owner - 1 (mod 2^CNT_W), go to RUN, count=0, assert gnt_owner and busy.
- RUN:
  - Each cycle, if count==term: go to DONE, pulse done_owner, keep gnt_owner, count returns to 0. Otherwise count increments by 1.
  - len inputs are ignored after latch. Changing len during RUN has no effect.
  - Owner drops req during RUN: abort. Next state IDLE, gnt cleared, count=0, no done, pointer still flips to the other requester.
  - Non-owner req is ignored until IDLE.
- DONE:
  - Lasts exactly one cycle with done_owner=1 and gnt_owner=1.
  - Next state IDLE; gnt and busy clear.
  - Pointer flips to favour the non-owner.
- Timing:
  - Req sampled high in IDLE at edge k gives gnt at k+1.
  - count runs 0..len-1 over len cycles; done is high in cycle k+1+len.
  - Total gnt high time is len+1 cycles.
  - At least one IDLE cycle between consecutive grants.
- len=1: RUN lasts one cycle with count=0, then DONE.
- len=0: term=all ones, giving 2^CNT_W RUN cycles; count wraps only via the DONE transition.
- gnt0 and gnt1 are never high together. done_x implies gnt_x in the same cycle.
- Same requester re-requesting after its done while the other is waiting loses to the other (fairness).

Test Plan:
- Reset hold:
  - Stimulus: reset=0 for 3 cycles with req0=req1=1.
  - Required: all outputs 0, count=0.
  - After release, gnt0 rises first (pointer reset favours 0).
- Single request:
  - Stimulus: req0=1, len0=5.
  - Required: gnt0 high 6 cycles, count sequence 0,1,2,3,4, done0 pulses once in the 6th cycle.
  - Then one IDLE cycle with gnt0=0, busy=0.
- Contention:
  - Stimulus: req0=req1=1 held, len0=3, len1=2.
  - Required grant order 0,1,0,1.
  - Each grant is separated by one IDLE cycle; done0 and done1 alternate; gnt0 and gnt1 are never both high.
- Boundary lengths:
  - len1=1 gives gnt1 for 2 cycles with count=0.
  - len1=0 gives 64 RUN cycles with count reaching 63, then done1.
- Abort:
  - Stimulus: req0 drops after count=2 of len0=8.
  - Required: next cycle IDLE, gnt0=0, no done0; next grant goes to req1 if pending.
- Mid-run reset and len change:
  - Changing len0 during RUN leaves the sequence unchanged.
  - reset=0 at count=4 clears all outputs at the next edge with no done pulse.

Source files
------------

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter sharing one interval counter between two requesters.
// Grants the counter, runs the latched interval and pulses a done per owner.
module interval_timer_arbiter #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [CNT_W-1:0] len0,
  input  logic             req1,
  input  logic [CNT_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;

  logic             pick_vld;
  logic             pick;
  logic             owner_req;
  logic [CNT_W-1:0] pick_len;

  // ptr_q/owner: 0 selects requester 0, 1 selects requester 1
  always_comb begin
    pick_vld  = req0 | req1;
    pick      = (req0 & req1) ? ptr_q : req1;
    pick_len  = pick ? len1 : len0;
    owner_req = owner_q ? req1 : req0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    term_d  = term_q;
    count_d = '0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_RUN;
          owner_d = pick;
          term_d  = pick_len - ONE;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          // owner withdrew: abort without done, still pass the turn
          state_d = S_IDLE;
          ptr_d   = ~owner_q;
        end else begin
          gnt0_d = ~owner_q;
          gnt1_d = owner_q;
          busy_d = 1'b1;
          if (count_q == term_q) begin
            state_d = S_DONE;
            done0_d = ~owner_q;
            done1_d = owner_q;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = ~owner_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      term_q  <= '0;
      count_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      term_q  <= term_d;
      count_q <= count_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Bench for interval_timer_arbiter: directed literal checks plus random
// traffic compared every cycle against an interval-level model.
module tb_interval_timer_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [5:0] len0 = '0;
  logic [5:0] len1 = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [5:0] count;

  int n_pass  = 0;
  int n_total = 0;

  interval_timer_arbiter #(.CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .req0 (req0),
    .len0 (len0),
    .req1 (req1),
    .len1 (len1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .done0(done0),
    .done1(done1),
    .busy (busy),
    .count(count)
  );

  always #5 clock = ~clock;

  // Model: an active interval of m_len ticks, m_el cycles since grant.
  bit m_act = 0;
  int m_el  = 0;
  int m_len = 0;
  int m_own = 0;
  int m_ptr = 0;

  task automatic model_step();
    int rq;
    if (!reset) begin
      m_act = 0;
      m_ptr = 0;
      m_el  = 0;
      m_own = 0;
      m_len = 0;
    end else if (!m_act) begin
      if (req0 || req1) begin
        m_own = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
        m_len = m_own ? int'(len1) : int'(len0);
        if (m_len == 0) m_len = 64;
        m_el  = 0;
        m_act = 1;
      end
    end else begin
      rq = m_own ? int'(req1) : int'(req0);
      if (m_el == m_len || rq == 0) begin
        m_act = 0;
        m_ptr = 1 - m_own;
      end else begin
        m_el++;
      end
    end
  endtask

  function automatic int e_gnt(int r);
    return (m_act && m_own == r) ? 1 : 0;
  endfunction

  function automatic int e_done(int r);
    return (m_act && m_el == m_len && m_own == r) ? 1 : 0;
  endfunction

  function automatic int e_count();
    return (m_act && m_el < m_len) ? m_el : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(posedge clock);
    #1;
    chk("m_gnt0", int'(gnt0), e_gnt(0));
    chk("m_gnt1", int'(gnt1), e_gnt(1));
    chk("m_done0", int'(done0), e_done(0));
    chk("m_done1", int'(done1), e_done(1));
    chk("m_busy", int'(busy), int'(m_act));
    chk("m_count", int'(count), e_count());
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic run_one(input int r, input logic [5:0] ln,
                         output int gcyc, output int maxc,
                         output int ndone, output int done_at);
    bit seen = 0;
    bit fin  = 0;
    logic g, d;
    gcyc = 0; maxc = -1; ndone = 0; done_at = 0;
    if (r == 0) begin req0 = 1'b1; len0 = ln; end
    else begin req1 = 1'b1; len1 = ln; end
    for (int i = 0; i < 200; i++) begin
      tick();
      g = r ? gnt1 : gnt0;
      d = r ? done1 : done0;
      if (g) begin
        seen = 1;
        gcyc++;
        if (int'(count) > maxc) maxc = int'(count);
        if (d) begin ndone++; done_at = gcyc; end
      end else if (seen) begin
        chk("idle_busy", int'(busy), 0);
        fin = 1;
        break;
      end
    end
    if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!fin) chk("run_timeout", 0, 1);
  endtask

  function automatic logic [5:0] rand_len();
    int v = $urandom_range(0, 31);
    if (v == 0) return 6'd0;
    if (v == 1) return 6'd1;
    if (v == 2) return 6'd63;
    return 6'($urandom_range(1, 8));
  endfunction

  task automatic rnd_req(input int r, input logic rq, input logic [5:0] ln,
                         output logic rq_o, output logic [5:0] ln_o);
    rq_o = rq;
    ln_o = ln;
    if (!rq) begin
      if ($urandom_range(0, 3) == 0) begin
        rq_o = 1'b1;
        ln_o = rand_len();
      end
    end else begin
      if (e_done(r) == 1) begin
        if ($urandom_range(0, 1) == 0) rq_o = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        rq_o = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) ln_o = rand_len();
    end
  endtask

  initial begin
    int gc, mc, nd, da, n_g, p0, p1;
    int order[4];
    bit hit;

    // reset hold with both requests asserted
    req0 = 1'b1; req1 = 1'b1; len0 = 6'd2; len1 = 6'd2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt0", int'(gnt0), 0);
      chk("rst_gnt1", int'(gnt1), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(count), 0);
    end
    reset = 1'b1;
    tick();
    chk("rst_first_gnt0", int'(gnt0), 1);
    chk("rst_first_gnt1", int'(gnt1), 0);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // single request len0=5
    do_reset();
    run_one(0, 6'd5, gc, mc, nd, da);
    chk("single_gnt_cycles", gc, 6);
    chk("single_max_count", mc, 4);
    chk("single_done_pulses", nd, 1);
    chk("single_done_cycle", da, 6);

    // contention: expect 0,1,0,1
    do_reset();
    len0 = 6'd3; len1 = 6'd2;
    req0 = 1'b1; req1 = 1'b1;
    n_g = 0; p0 = 0; p1 = 0;
    for (int i = 0; i < 40 && n_g < 4; i++) begin
      tick();
      if (gnt0 && p0 == 0) begin order[n_g] = 0; n_g++; end
      else if (gnt1 && p1 == 0) begin order[n_g] = 1; n_g++; end
      p0 = int'(gnt0); p1 = int'(gnt1);
    end
    chk("cont_grant_count", n_g, 4);
    for (int i = 0; i < n_g; i++) chk("cont_order", order[i], i % 2);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // boundary lengths on requester 1
    do_reset();
    run_one(1, 6'd1, gc, mc, nd, da);
    chk("len1_gnt_cycles", gc, 2);
    chk("len1_max_count", mc, 0);
    chk("len1_done_cycle", da, 2);
    do_reset();
    run_one(1, 6'd0, gc, mc, nd, da);
    chk("len0_gnt_cycles", gc, 65);
    chk("len0_max_count", mc, 63);
    chk("len0_done_pulses", nd, 1);
    chk("len0_done_cycle", da, 65);

    // abort at count 2 with requester 1 pending
    do_reset();
    len0 = 6'd8; len1 = 6'd3;
    req0 = 1'b1; req1 = 1'b1;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt0 && count == 6'd2) begin hit = 1; break; end
    end
    chk("abort_reach_cnt2", int'(hit), 1);
    req0 = 1'b0;
    tick();
    chk("abort_gnt0", int'(gnt0), 0);
    chk("abort_done0", int'(done0), 0);
    chk("abort_busy", int'(busy), 0);
    tick();
    chk("abort_next_gnt1", int'(gnt1), 1);
    for (int i = 0; i < 6; i++) tick();
    req1 = 1'b0;
    tick(); tick();

    // len change mid-run ignored, then reset at count 4
    do_reset();
    len0 = 6'd6; req0 = 1'b1;
    tick();
    chk("lchg_gnt0", int'(gnt0), 1);
    len0 = 6'd2;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lchg_no_early_done", int'(done0), 0);
      if (count == 6'd4) begin hit = 1; break; end
    end
    chk("lchg_reach_cnt4", int'(hit), 1);
    reset = 1'b0;
    tick();
    chk("mrst_gnt0", int'(gnt0), 0);
    chk("mrst_done0", int'(done0), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_count", int'(count), 0);
    reset = 1'b1;
    req0 = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rnd_req(0, req0, len0, req0, len0);
      rnd_req(1, req1, len1, req1, len1);
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
